// File: rtl/coco_bus_pkg.sv
// Shared encodings for the CoCo bus sequencer: E/Q phase codes, DMA arbiter states and
// quarter-counter width.
package coco_bus_pkg;

  localparam int unsigned QCNT_W = 8;
  typedef logic [QCNT_W-1:0] qcnt_t;

  typedef logic [1:0] phase_t;
  localparam phase_t PhLow = 2'd0;  // E=0 Q=0
  localparam phase_t PhQ   = 2'd1;  // E=0 Q=1
  localparam phase_t PhEq  = 2'd2;  // E=1 Q=1
  localparam phase_t PhE   = 2'd3;  // E=1 Q=0

  typedef logic [1:0] dma_st_t;
  localparam dma_st_t DmaIdle   = 2'd0;
  localparam dma_st_t DmaHalt   = 2'd1;
  localparam dma_st_t DmaWaitBa = 2'd2;
  localparam dma_st_t DmaGrant  = 2'd3;

  // Returns {E, Q} for a phase; Q leads E by one quarter.
  function automatic logic [1:0] phase_eq(phase_t ph);
    return {ph[1], ph[1] ^ ph[0]};
  endfunction

endpackage

// File: rtl/coco_bus_sequencer_if.sv
// Bus bundle between the sequencer and the CPU, video generator, DMA requester and RAM.
interface coco_bus_sequencer_if;

  logic        rate_fast;
  logic        E;
  logic        Q;
  logic [15:0] cpu_addr;
  logic        cpu_rnw;
  logic        cpu_ba;
  logic        cpu_bs;
  logic        cpu_nhalt;
  logic [15:0] vid_addr;
  logic        vid_en;
  logic        vid_latch;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_rnw;
  logic        dma_gnt;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic        cyc_end;

  modport master (
    input  rate_fast, cpu_addr, cpu_rnw, cpu_ba, cpu_bs, vid_addr, vid_en,
           dma_req, dma_addr, dma_rnw,
    output E, Q, cpu_nhalt, vid_latch, dma_gnt, ram_addr, ram_we, cyc_end
  );

  modport slave (
    output rate_fast, cpu_addr, cpu_rnw, cpu_ba, cpu_bs, vid_addr, vid_en,
           dma_req, dma_addr, dma_rnw,
    input  E, Q, cpu_nhalt, vid_latch, dma_gnt, ram_addr, ram_we, cyc_end
  );

endinterface

// File: rtl/eq_clkgen.sv
// E/Q quadrature generator: quarter counter, phase counter and per-cycle rate latch.
module eq_clkgen
  import coco_bus_pkg::*;
#(
  parameter int unsigned SLOW_QTR = 4,
  parameter int unsigned FAST_QTR = 2
) (
  input  logic   clk,
  input  logic   nRESET,
  input  logic   i_rate_fast,
  output phase_t o_phase,
  output logic   o_phase_end,
  output logic   o_e,
  output logic   o_q,
  output logic   o_cyc_end
);

  localparam qcnt_t SlowQtr = qcnt_t'(SLOW_QTR);
  localparam qcnt_t FastQtr = qcnt_t'(FAST_QTR);

  qcnt_t  r_qcnt;
  qcnt_t  r_qtr;
  phase_t r_phase;
  logic   r_e;
  logic   r_q;

  logic   w_phase_end;
  logic   w_cyc_end;
  phase_t w_phase_next;

  assign w_phase_end  = (r_qcnt == (r_qtr - qcnt_t'(1)));
  assign w_cyc_end    = w_phase_end && (r_phase == PhE);
  assign w_phase_next = w_phase_end ? (r_phase + phase_t'(1)) : r_phase;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_qcnt  <= '0;
      r_qtr   <= SlowQtr;
      r_phase <= PhLow;
      r_e     <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      r_qcnt     <= w_phase_end ? '0 : (r_qcnt + qcnt_t'(1));
      r_phase    <= w_phase_next;
      {r_e, r_q} <= phase_eq(w_phase_next);
      // Rate only changes on the E-cycle boundary so a cycle is never cut short.
      if (w_cyc_end) begin
        r_qtr <= i_rate_fast ? FastQtr : SlowQtr;
      end
    end
  end

  assign o_phase     = r_phase;
  assign o_phase_end = w_phase_end;
  assign o_e         = r_e;
  assign o_q         = r_q;
  assign o_cyc_end   = w_cyc_end;

endmodule

// File: rtl/coco_bus_sequencer.sv
// SAM-style bus sequencer: E/Q generation, video/CPU/DMA RAM address time-slicing and
// DMA arbitration by halting the CPU.
module coco_bus_sequencer
  import coco_bus_pkg::*;
#(
  parameter int unsigned SLOW_QTR = 4,
  parameter int unsigned FAST_QTR = 2
) (
  input logic                  clk,
  input logic                  nRESET,
  coco_bus_sequencer_if.master bus
);

  phase_t w_phase;
  phase_t w_phase_next;
  logic   w_phase_end;
  logic   w_cyc_end;
  logic   w_e;
  logic   w_q;

  eq_clkgen #(
    .SLOW_QTR(SLOW_QTR),
    .FAST_QTR(FAST_QTR)
  ) u_clkgen (
    .clk        (clk),
    .nRESET     (nRESET),
    .i_rate_fast(bus.rate_fast),
    .o_phase    (w_phase),
    .o_phase_end(w_phase_end),
    .o_e        (w_e),
    .o_q        (w_q),
    .o_cyc_end  (w_cyc_end)
  );

  assign w_phase_next = w_phase + phase_t'(w_phase_end);

  dma_st_t r_dma_st;
  dma_st_t w_dma_st_d;
  logic    r_gnt;
  logic    w_gnt_d;
  logic    r_nhalt;
  logic    w_nhalt_d;

  // Arbiter only moves on E falling, so grant never changes inside an E-high slot.
  always_comb begin
    w_dma_st_d = r_dma_st;
    w_gnt_d    = r_gnt;
    w_nhalt_d  = r_nhalt;
    if (w_cyc_end) begin
      case (r_dma_st)
        DmaIdle: begin
          if (bus.dma_req) begin
            w_dma_st_d = DmaHalt;
            w_nhalt_d  = 1'b0;
          end
        end
        DmaHalt: begin
          if (!bus.dma_req) begin
            w_dma_st_d = DmaIdle;
            w_nhalt_d  = 1'b1;
          end else begin
            w_dma_st_d = DmaWaitBa;
          end
        end
        DmaWaitBa: begin
          if (!bus.dma_req) begin
            w_dma_st_d = DmaIdle;
            w_nhalt_d  = 1'b1;
          end else if (bus.cpu_ba && bus.cpu_bs) begin
            w_dma_st_d = DmaGrant;
            w_gnt_d    = 1'b1;
          end
        end
        DmaGrant: begin
          if (!bus.dma_req) begin
            w_dma_st_d = DmaIdle;
            w_gnt_d    = 1'b0;
            w_nhalt_d  = 1'b1;
          end
        end
        default: begin
          w_dma_st_d = DmaIdle;
          w_gnt_d    = 1'b0;
          w_nhalt_d  = 1'b1;
        end
      endcase
    end
  end

  logic [15:0] r_ram_addr;
  logic [15:0] w_ram_addr_d;
  logic        r_ram_we;
  logic        w_ram_we_d;
  logic        w_own_rnw;

  assign w_own_rnw = r_gnt ? bus.dma_rnw : bus.cpu_rnw;

  always_comb begin
    w_ram_addr_d = r_ram_addr;
    w_ram_we_d   = 1'b0;
    if (!w_phase_next[1]) begin
      if (bus.vid_en) begin
        w_ram_addr_d = bus.vid_addr;
      end
    end else begin
      w_ram_addr_d = r_gnt ? bus.dma_addr : bus.cpu_addr;
      w_ram_we_d   = (w_phase_next == PhE) && !w_own_rnw;
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_dma_st   <= DmaIdle;
      r_gnt      <= 1'b0;
      r_nhalt    <= 1'b1;
      r_ram_addr <= '0;
      r_ram_we   <= 1'b0;
    end else begin
      r_dma_st   <= w_dma_st_d;
      r_gnt      <= w_gnt_d;
      r_nhalt    <= w_nhalt_d;
      r_ram_addr <= w_ram_addr_d;
      r_ram_we   <= w_ram_we_d;
    end
  end

  assign bus.E         = w_e;
  assign bus.Q         = w_q;
  assign bus.cyc_end   = w_cyc_end;
  assign bus.vid_latch = w_phase_end && (w_phase == PhQ) && bus.vid_en;
  assign bus.cpu_nhalt = r_nhalt;
  assign bus.dma_gnt   = r_gnt;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_we    = r_ram_we;

endmodule

// File: tb/tb_coco_bus_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle-position
// reference model of the sequencer.
module tb_coco_bus_sequencer;

  localparam int SLOW = 4;
  localparam int FAST = 2;

  logic clk;
  logic nRESET;
  int   n_checks = 0;
  int   n_fail   = 0;

  coco_bus_sequencer_if bus ();

  coco_bus_sequencer #(
    .SLOW_QTR(SLOW),
    .FAST_QTR(FAST)
  ) dut (
    .clk   (clk),
    .nRESET(nRESET),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position inside the E cycle, current quarter length, arbiter stage.
  int          m_pos;
  int          m_qtr;
  int          m_st;  // 0 idle, 1 halt requested, 2 waiting for BA/BS, 3 granted
  logic        m_gnt;
  logic        m_nhalt;
  logic [15:0] m_addr;
  logic        m_we;

  task automatic model_reset();
    m_pos   = 0;
    m_qtr   = SLOW;
    m_st    = 0;
    m_gnt   = 1'b0;
    m_nhalt = 1'b1;
    m_addr  = 16'h0;
    m_we    = 1'b0;
  endtask

  task automatic model_step();
    int nph;
    if (m_pos == 4 * m_qtr - 1) begin
      m_pos = 0;
      m_qtr = bus.rate_fast ? FAST : SLOW;
      case (m_st)
        0: if (bus.dma_req) begin m_st = 1; m_nhalt = 1'b0; end
        1: if (!bus.dma_req) begin m_st = 0; m_nhalt = 1'b1; end else m_st = 2;
        2: if (!bus.dma_req) begin m_st = 0; m_nhalt = 1'b1; end
           else if (bus.cpu_ba && bus.cpu_bs) begin m_st = 3; m_gnt = 1'b1; end
        default: if (!bus.dma_req) begin m_st = 0; m_gnt = 1'b0; m_nhalt = 1'b1; end
      endcase
    end else begin
      m_pos = m_pos + 1;
    end
    nph = m_pos / m_qtr;
    if (nph < 2) begin
      if (bus.vid_en) m_addr = bus.vid_addr;
      m_we = 1'b0;
    end else begin
      m_addr = m_gnt ? bus.dma_addr : bus.cpu_addr;
      m_we   = (nph == 3) && !(m_gnt ? bus.dma_rnw : bus.cpu_rnw);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge nRESET);
      if (!nRESET) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int ph;
    ph = m_pos / m_qtr;
    check("E", bus.E, (ph >= 2));
    check("Q", bus.Q, (ph == 1 || ph == 2));
    check("cyc_end", bus.cyc_end, (m_pos == 4 * m_qtr - 1));
    check("vid_latch", bus.vid_latch,
          bus.vid_en && (ph == 1) && (m_pos % m_qtr == m_qtr - 1));
    check("dma_gnt", bus.dma_gnt, m_gnt);
    check("cpu_nhalt", bus.cpu_nhalt, m_nhalt);
    check("ram_addr", bus.ram_addr, m_addr);
    check("ram_we", bus.ram_we, m_we);
  end

  logic gnt_watch = 1'b0;
  logic gnt_seen  = 1'b0;
  always @(negedge clk) if (gnt_watch && bus.dma_gnt) gnt_seen <= 1'b1;

  // Counts negedges up to and including the next cyc_end sample.
  task automatic wait_cyc(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cyc_end && n < 100);
    check("cyc_end_seen", bus.cyc_end, 1'b1);
  endtask

  initial begin
    int n, cnt, k, e_rise0, e_rise1, q_rise0, n_cyc;
    logic e_prev, q_prev;

    nRESET        = 1'b0;
    bus.rate_fast = 1'b0;
    bus.cpu_addr  = 16'h0;
    bus.cpu_rnw   = 1'b1;
    bus.cpu_ba    = 1'b0;
    bus.cpu_bs    = 1'b0;
    bus.vid_addr  = 16'h0;
    bus.vid_en    = 1'b0;
    bus.dma_req   = 1'b0;
    bus.dma_addr  = 16'h0;
    bus.dma_rnw   = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_E", bus.E, 1'b0);
    check("rst_Q", bus.Q, 1'b0);
    check("rst_nhalt", bus.cpu_nhalt, 1'b1);
    check("rst_gnt", bus.dma_gnt, 1'b0);
    check("rst_addr", bus.ram_addr, 16'h0);
    #1 nRESET = 1'b1;

    // Slow-mode waveform shape.
    e_prev = 1'b0; q_prev = 1'b0; e_rise0 = -1; e_rise1 = -1; q_rise0 = -1; n_cyc = 0;
    for (k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (bus.E && !e_prev) begin
        if (e_rise0 < 0) e_rise0 = k;
        else if (e_rise1 < 0) e_rise1 = k;
      end
      if (bus.Q && !q_prev && q_rise0 < 0) q_rise0 = k;
      if (bus.cyc_end) n_cyc++;
      e_prev = bus.E;
      q_prev = bus.Q;
    end
    check("e_period_slow", e_rise1 - e_rise0, 16);
    check("q_lead", e_rise0 - q_rise0, 4);
    check("first_e_rise", e_rise0, 8);
    check("cyc_end_count", n_cyc, 4);

    // Rate change in phase 1 takes effect from the next cycle only.
    wait_cyc(n);
    repeat (6) @(negedge clk);
    check("in_phase1", {bus.E, bus.Q}, 2'b01);
    #1 bus.rate_fast = 1'b1;
    wait_cyc(n);
    check("len_cur_cycle", n + 6, 16);
    wait_cyc(n);
    check("len_fast_cycle", n, 8);
    #1 bus.rate_fast = 1'b0;
    wait_cyc(n);
    check("len_slow_again", n, 16);

    // Video slot and CPU write slot.
    #1;
    bus.vid_en   = 1'b1;
    bus.vid_addr = 16'h0400;
    bus.cpu_addr = 16'hA000;
    bus.cpu_rnw  = 1'b0;
    n_cyc = 0;
    for (int p = 0; p < 16; p++) begin
      @(negedge clk);
      check("vid_slot_addr", bus.ram_addr, (p < 8) ? 16'h0400 : 16'hA000);
      check("vid_slot_we", bus.ram_we, (p >= 12));
      if (bus.vid_latch) n_cyc++;
    end
    check("vid_latch_pulses", n_cyc, 1);
    #1;
    bus.vid_en  = 1'b0;
    bus.cpu_rnw = 1'b1;

    // DMA request with CPU acknowledging after halt.
    bus.dma_req  = 1'b1;
    bus.dma_addr = 16'h1234;
    bus.dma_rnw  = 1'b0;
    @(negedge clk);
    check("halt_falls", bus.cpu_nhalt, 1'b0);
    #1;
    bus.cpu_ba = 1'b1;
    bus.cpu_bs = 1'b1;
    cnt = 0;
    do begin
      wait_cyc(n);
      @(negedge clk);
      cnt++;
    end while (!bus.dma_gnt && cnt < 6);
    check("gnt_latency_cycles", cnt, 2);
    for (int p = 0; p < 15; p++) begin
      if (p > 0) @(negedge clk);
      if (p >= 8) check("dma_slot_addr", bus.ram_addr, 16'h1234);
      check("dma_slot_we", bus.ram_we, (p >= 12));
    end
    #1;
    bus.dma_req = 1'b0;
    bus.cpu_ba  = 1'b0;
    bus.cpu_bs  = 1'b0;
    wait_cyc(n);
    @(negedge clk);
    check("release_gnt", bus.dma_gnt, 1'b0);
    check("release_nhalt", bus.cpu_nhalt, 1'b1);

    // One-cycle request while BA stays low aborts without a grant.
    gnt_watch = 1'b1;
    wait_cyc(n);
    #1 bus.dma_req = 1'b1;
    @(negedge clk);
    check("abort_halt", bus.cpu_nhalt, 1'b0);
    wait_cyc(n);
    #1 bus.dma_req = 1'b0;
    @(negedge clk);
    check("abort_nhalt", bus.cpu_nhalt, 1'b1);
    repeat (40) @(negedge clk);
    check("abort_no_gnt", gnt_seen, 1'b0);
    gnt_watch = 1'b0;

    // Reset during a granted E-high slot, in fast mode.
    #1;
    bus.rate_fast = 1'b1;
    bus.dma_req   = 1'b1;
    bus.cpu_ba    = 1'b1;
    bus.cpu_bs    = 1'b1;
    cnt = 0;
    while (!bus.dma_gnt && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("gnt_reached", bus.dma_gnt, 1'b1);
    cnt = 0;
    while (!bus.E && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("e_high_reached", bus.E, 1'b1);
    #1 nRESET = 1'b0;
    #1;
    check("arst_E", bus.E, 1'b0);
    check("arst_Q", bus.Q, 1'b0);
    check("arst_gnt", bus.dma_gnt, 1'b0);
    check("arst_nhalt", bus.cpu_nhalt, 1'b1);
    check("arst_we", bus.ram_we, 1'b0);
    bus.dma_req = 1'b0;
    repeat (2) @(negedge clk);
    #1 nRESET = 1'b1;
    wait_cyc(n);
    check("post_rst_slow_len", n, 15);
    wait_cyc(n);
    check("post_rst_fast_len", n, 8);

    // Randomized traffic against the model, with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(63) == 0) bus.rate_fast = ~bus.rate_fast;
      if ($urandom_range(39) == 0) bus.dma_req = ~bus.dma_req;
      bus.cpu_addr = 16'($urandom);
      bus.cpu_rnw  = 1'($urandom_range(1));
      bus.cpu_ba   = ($urandom_range(3) != 0);
      bus.cpu_bs   = ($urandom_range(3) != 0);
      bus.vid_addr = 16'($urandom);
      bus.vid_en   = 1'($urandom_range(1));
      bus.dma_addr = 16'($urandom);
      bus.dma_rnw  = 1'($urandom_range(1));
      if (i == 1500) begin
        nRESET = 1'b0;
        repeat (2) @(negedge clk);
        #1 nRESET = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coco_bus_sequencer.md
# coco_bus_sequencer

Generates the E/Q quadrature clocks for the 6809E core from the single system clock, time-slices the shared RAM address bus between video fetch (E low) and CPU or DMA access (E high), and arbitrates DMA bus ownership by halting the CPU. It sits between the CPU core, the video address generator and the RAM, in the position the SAM occupies on the board.

## Interface
- SLOW_QTR, 4: clk cycles per quarter E cycle in slow mode (1..255)
- FAST_QTR, 2: clk cycles per quarter E cycle in fast mode (1..255)
- clk  in  1  system clock
- nRESET  in  1  reset; asynchronous, active-low
- rate_fast  in  1  1 = use FAST_QTR
- E  out  1  6809E E clock
- Q  out  1  6809E Q clock (leads E by 90°)
- cpu_addr  in  16  CPU address
- cpu_rnw  in  1  CPU read/not-write
- cpu_ba, cpu_bs  in  1 each  CPU bus status
- cpu_nhalt  out  1  to CPU nHALT
- vid_addr  in  16  video fetch address
- vid_en  in  1  video fetch wanted this cycle
- vid_latch  out  1  one-clk pulse: RAM data is valid video data
- dma_req  in  1  DMA requester wants the bus (level)
- dma_addr  in  16  DMA address
- dma_rnw  in  1  DMA read/not-write
- dma_gnt  out  1  DMA owns the E-high slot
- ram_addr  out  16  RAM address
- ram_we  out  1  RAM write enable
- cyc_end  out  1  one-clk pulse on the last clk of each E cycle

## Operation
- 2-bit phase, 8-bit quarter counter qcnt. qcnt counts 0..QTR-1; at QTR-1 phase increments (mod 4), qcnt clears.
- Registered outputs: phase 0: E=0 Q=0; 1: E=0 Q=1; 2: E=1 Q=1; 3: E=1 Q=0.
- QTR is latched from rate_fast on the last clk of phase 3 only; it takes effect from the following phase 0. A rate_fast change mid-cycle never shortens or stretches the current cycle.
- Address slots (registered):
  - Phases 0–1: ram_addr = vid_addr if vid_en, else it holds. ram_we=0.
  - Phases 2–3: ram_addr = dma_addr if dma_gnt, else cpu_addr.
- ram_we=1 throughout phase 3 when the slot owner's rnw=0. During WAIT_BA the slot owner is the CPU.
- vid_latch pulses on the last clk of phase 1 when vid_en was 1 at that clk.
- DMA FSM. All transitions are evaluated on the cyc_end clk (E falling):
  - IDLE: on dma_req=1 → HALT, and cpu_nhalt drops to 0.
  - HALT: → WAIT_BA.
  - WAIT_BA: on cpu_ba=1 and cpu_bs=1 → GRANT, and dma_gnt rises to 1.
  - GRANT: on dma_req=0 → IDLE, with dma_gnt=0 and cpu_nhalt=1 on the same edge.
  - dma_req=0 seen in HALT or WAIT_BA → IDLE, and cpu_nhalt returns to 1.
  - dma_req is ignored at all other clks.

## Timing
- Reset values: E=0, Q=0, cpu_nhalt=1, dma_gnt=0, ram_addr=0, ram_we=0, vid_latch=0, cyc_end=0, FSM=IDLE, phase=0, qcnt=0, QTR=SLOW_QTR.
- Deassertion of reset: phase 0 begins on the first clk edge after deassertion.
- Assertion of reset mid-cycle or mid-DMA: every output returns immediately to its reset value, including cpu_nhalt=1 and dma_gnt=0.
- E cycle length: 4·QTR clks, so 16 slow and 8 fast at the default parameters.
- Latency from the dma_req rising edge to dma_gnt: minimum 2 E cycles, HALT plus one WAIT_BA check.
- dma_gnt changes only on cyc_end, so an E-high slot never has mixed ownership.
- QTR=1: every phase lasts one clk. vid_latch and cyc_end still fire once per cycle.

## Structure
- Shared package `coco_bus_pkg`: phase encoding constants, DMA FSM state enum, and the 8-bit quarter-counter width.
- Natural sub-module: `eq_clkgen`. It contains the qcnt, phase, QTR latch and E/Q/cyc_end logic, and exports phase and the end-of-phase strobe. Arbitration and address muxing stay in the top level.

## Test plan
- Reset, then 64 clks at rate_fast=0 → E period 16, Q rising 4 clks before E rising, cyc_end every 16th clk, all other outputs at reset values.
- rate_fast 0→1 asserted in phase 1 → the current cycle completes at 16 clks and the next cycle is 8 clks.
- vid_en=1, vid_addr=0x0400, cpu_addr=0xA000, cpu_rnw=0 → ram_addr=0x0400 in phases 0–1 with one vid_latch pulse, ram_addr=0xA000 in phases 2–3, ram_we=1 only in phase 3.
- dma_req=1, cpu_ba/bs tied to 1 after cpu_nhalt falls, dma_addr=0x1234, dma_rnw=0 → dma_gnt rises 2 cycles after request, E-high ram_addr=0x1234 with ram_we in phase 3; dma_req=0 → dma_gnt=0 and cpu_nhalt=1 on the next cyc_end.
- dma_req pulsed high for 1 E cycle while cpu_ba stays 0 → FSM aborts to IDLE, cpu_nhalt returns to 1, dma_gnt never asserts.
- nRESET asserted during GRANT at phase 2 → dma_gnt=0, cpu_nhalt=1, E=Q=0 immediately; after release the sequence restarts at phase 0 in slow mode.
